// File: rtl/ah_resp_encoder.sv
// ============================================================================
// Module   : ah_resp_encoder
// Purpose  : Round-robin response-return arbiter and one-hot-to-binary encoder
//            feeding a single registered valid/ready egress port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ah_resp_encoder #(
    parameter int NUM_CLIENTS = 8,
    parameter int ID_W        = 3,
    parameter int DATA_W      = 34
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        client_req,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_pkt_field,
    output logic [NUM_CLIENTS-1:0]        client_ack,
    output logic                          egress_valid,
    input  logic                          egress_ready,
    output logic [DATA_W-1:0]             egress_pkt_field,
    output logic [ID_W-1:0]               egress_client_id,
    output logic                          enc_err
);

    localparam logic [ID_W:0]   c_num_clients = (ID_W+1)'(NUM_CLIENTS);
    localparam logic [ID_W-1:0] c_last_id     = ID_W'(NUM_CLIENTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [NUM_CLIENTS-1:0]  r_req_q;
    logic [NUM_CLIENTS-1:0]  w_elig;
    logic                    w_found;
    logic [ID_W-1:0]         w_winner;
    logic [ID_W:0]           w_idx;
    logic [DATA_W-1:0]       w_sel_field;
    logic                    w_capture;
    logic                    w_release;

    // The client acked this cycle must not win again before it sees its ack.
    assign w_elig = client_req & ~client_ack;

    // Scan from the round-robin pointer upward, wrapping at NUM_CLIENTS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= c_num_clients) begin
                w_idx = w_idx - c_num_clients;
            end
            if (!w_found && w_elig[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_field = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_field = client_pkt_field[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                w_capture = w_found;
            end
            ST_HOLD: begin
                w_capture = egress_ready && w_found;
                w_release = egress_ready && !w_found;
            end
            default: begin
                w_capture = 1'b0;
            end
        endcase
        if (w_capture) begin
            w_state_nxt = ST_HOLD;
        end else if (w_release) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            egress_valid     <= 1'b0;
            egress_pkt_field <= '0;
            egress_client_id <= '0;
            client_ack       <= '0;
            enc_err          <= 1'b0;
            r_rr_ptr         <= '0;
            r_req_q          <= '0;
        end else begin
            client_ack <= '0;
            if (w_capture) begin
                egress_valid     <= 1'b1;
                egress_pkt_field <= w_sel_field;
                egress_client_id <= w_winner;
                client_ack       <= NUM_CLIENTS'(1) << w_winner;
                r_rr_ptr         <= (w_winner == c_last_id) ? '0 : w_winner + ID_W'(1);
            end else if (w_release) begin
                egress_valid <= 1'b0;
            end
            // Acked requests leave the pending set so the post-ack drop is legal.
            r_req_q <= client_req & ~client_ack;
            enc_err <= |(r_req_q & ~client_req & ~client_ack);
        end
    end

endmodule

`default_nettype wire
